// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_e;

    // Total sysclk cycles taken by one serial frame.
    function automatic int unsigned uart_frame_len(
        input int unsigned clks_per_bit,
        input int unsigned data_bits,
        input int unsigned parity,
        input int unsigned stop_bits
    );
        return clks_per_bit * (1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// CPU-side bus of the buffered UART transmitter plus its serial line.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             wr_en;
    logic [7:0]       wr_data;
    logic             ovf_clear;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             overflow;
    logic             uart_tx;

    modport master (
        output wr_en, wr_data, ovf_clear,
        input  full, empty, count, busy, overflow, uart_tx
    );

    modport slave (
        input  wr_en, wr_data, ovf_clear,
        output full, empty, count, busy, overflow, uart_tx
    );

endinterface

// File: rtl/uart_tx_fifo_fifo.sv
// Synchronous FIFO with show-ahead read port and same-cycle push+pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               din_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               dout_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Qualify requests against occupancy and compute next pointers/count.
    always_comb begin
        do_push  = push_i && (count_q != CNT_W'(DEPTH));
        do_pop   = pop_i && (count_q != '0);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO drained by a frame serialiser.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic           sysclk,
    input  logic           cpu_reset,
    uart_tx_fifo_if.slave  bus
);
    localparam int            CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int            BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    DATA_MASK = 8'((9'd1 << DATA_BITS) - 9'd1);
    localparam parity_e       PAR_MODE  = parity_e'(PARITY[1:0]);
    localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    tx_state_e        state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             par_q;
    logic             tx_q;
    logic             busy_q;
    logic             overflow_q;
    logic             load_par;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (sysclk),
        .rst_i   (cpu_reset),
        .push_i  (bus.wr_en),
        .din_i   (bus.wr_data),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Pop when idle, or on the last cycle of the final stop bit so frames chain without a gap.
    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            if (state_q == IDLE) begin
                fifo_pop = 1'b1;
            end else if (state_q == STOP && baud_q == '0 && bit_q == LAST_STOP) begin
                fifo_pop = 1'b1;
            end
        end
    end

    // Parity of the head byte, restricted to the configured data width.
    always_comb begin
        load_par = ^(fifo_dout & DATA_MASK);
        if (PAR_MODE == ODD) begin
            load_par = ~load_par;
        end
    end

    // Serialiser FSM: baud down-counter, bit index, shift register and registered line.
    always_ff @(posedge sysclk) begin
        if (cpu_reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else if (state_q == IDLE) begin
            if (!fifo_empty) begin
                state_q <= START;
                shift_q <= fifo_dout;
                par_q   <= load_par;
                baud_q  <= BAUD_LOAD;
                tx_q    <= 1'b0;
                busy_q  <= 1'b1;
            end
        end else if (baud_q != '0) begin
            baud_q <= baud_q - 1'b1;
        end else begin
            baud_q <= BAUD_LOAD;
            case (state_q)
                START: begin
                    state_q <= DATA;
                    tx_q    <= shift_q[0];
                    shift_q <= {1'b0, shift_q[7:1]};
                    bit_q   <= '0;
                end
                DATA: begin
                    if (bit_q == LAST_DATA) begin
                        bit_q <= '0;
                        if (PAR_MODE != NONE) begin
                            state_q <= PAR;
                            tx_q    <= par_q;
                        end else begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        bit_q   <= bit_q + 1'b1;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                    end
                end
                PAR: begin
                    state_q <= STOP;
                    tx_q    <= 1'b1;
                    bit_q   <= '0;
                end
                STOP: begin
                    if (bit_q != LAST_STOP) begin
                        bit_q <= bit_q + 1'b1;
                    end else if (!fifo_empty) begin
                        state_q <= START;
                        shift_q <= fifo_dout;
                        par_q   <= load_par;
                        tx_q    <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow: a dropped write wins over a same-cycle clear.
    always_ff @(posedge sysclk) begin
        if (cpu_reset) begin
            overflow_q <= 1'b0;
        end else if (bus.wr_en && fifo_full) begin
            overflow_q <= 1'b1;
        end else if (bus.ovf_clear) begin
            overflow_q <= 1'b0;
        end
    end

    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.count    = fifo_count;
    assign bus.busy     = busy_q;
    assign bus.overflow = overflow_q;
    assign bus.uart_tx  = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench: three configurations (8N1, 7E2, 8O1) checked every cycle
// against a queue-based model of FIFO contents and pending line levels.
module tb_uart_tx_fifo;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned NI    = 3;

    int unsigned DB [NI] = '{8, 7, 8};
    int unsigned PM [NI] = '{0, 2, 1};
    int unsigned SB [NI] = '{1, 2, 1};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       we  [NI];
    logic [7:0] wd  [NI];
    logic       clr [NI];

    logic       o_tx   [NI];
    logic       o_busy [NI];
    logic       o_full [NI];
    logic       o_emp  [NI];
    logic       o_ovf  [NI];
    logic [4:0] o_cnt  [NI];

    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) ifa ();
    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) ifb ();
    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) ifc ();

    assign ifa.wr_en = we[0];  assign ifa.wr_data = wd[0];  assign ifa.ovf_clear = clr[0];
    assign ifb.wr_en = we[1];  assign ifb.wr_data = wd[1];  assign ifb.ovf_clear = clr[1];
    assign ifc.wr_en = we[2];  assign ifc.wr_data = wd[2];  assign ifc.ovf_clear = clr[2];

    assign o_tx[0] = ifa.uart_tx; assign o_busy[0] = ifa.busy; assign o_full[0] = ifa.full;
    assign o_emp[0] = ifa.empty;  assign o_ovf[0] = ifa.overflow; assign o_cnt[0] = ifa.count;
    assign o_tx[1] = ifb.uart_tx; assign o_busy[1] = ifb.busy; assign o_full[1] = ifb.full;
    assign o_emp[1] = ifb.empty;  assign o_ovf[1] = ifb.overflow; assign o_cnt[1] = ifb.count;
    assign o_tx[2] = ifc.uart_tx; assign o_busy[2] = ifc.busy; assign o_full[2] = ifc.full;
    assign o_emp[2] = ifc.empty;  assign o_ovf[2] = ifc.overflow; assign o_cnt[2] = ifc.count;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
        dut_a (.sysclk(clk), .cpu_reset(rst), .bus(ifa));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH))
        dut_b (.sysclk(clk), .cpu_reset(rst), .bus(ifb));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
        dut_c (.sysclk(clk), .cpu_reset(rst), .bus(ifc));

    // Model state: queued bytes, and the line levels still to appear (one entry per cycle).
    logic [7:0] mf [NI][$];
    logic       ml [NI][$];
    logic       movf [NI];

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned rise_cyc [NI];
    int unsigned last_len [NI];
    logic        prev_busy [NI];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void append_frame(input int unsigned i, input logic [7:0] b);
        logic p;
        p = 1'b0;
        for (int unsigned r = 0; r < CPB; r++) ml[i].push_back(1'b0);
        for (int unsigned k = 0; k < DB[i]; k++) begin
            p = p ^ b[k];
            for (int unsigned r = 0; r < CPB; r++) ml[i].push_back(b[k]);
        end
        if (PM[i] != 0) begin
            if (PM[i] == 1) p = ~p;
            for (int unsigned r = 0; r < CPB; r++) ml[i].push_back(p);
        end
        for (int unsigned r = 0; r < CPB * SB[i]; r++) ml[i].push_back(1'b1);
    endfunction

    task automatic model_edge();
        for (int unsigned i = 0; i < NI; i++) begin
            if (rst) begin
                mf[i].delete();
                ml[i].delete();
                movf[i] = 1'b0;
            end else begin
                int unsigned pre;
                logic        popped;
                pre    = mf[i].size();
                popped = (ml[i].size() <= 1) && (pre > 0);
                if (ml[i].size() > 0) void'(ml[i].pop_front());
                if (popped) append_frame(i, mf[i].pop_front());
                if (we[i] && pre == DEPTH) movf[i] = 1'b1;
                else if (clr[i]) movf[i] = 1'b0;
                if (we[i] && pre < DEPTH) mf[i].push_back(wd[i]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        for (int unsigned i = 0; i < NI; i++) begin
            check_eq($sformatf("tx%0d", i), 32'(o_tx[i]), 32'((ml[i].size() > 0) ? ml[i][0] : 1'b1));
            check_eq($sformatf("busy%0d", i), 32'(o_busy[i]), 32'(ml[i].size() > 0));
            check_eq($sformatf("count%0d", i), 32'(o_cnt[i]), 32'(mf[i].size()));
            check_eq($sformatf("full%0d", i), 32'(o_full[i]), 32'(mf[i].size() == DEPTH));
            check_eq($sformatf("empty%0d", i), 32'(o_emp[i]), 32'(mf[i].size() == 0));
            check_eq($sformatf("ovf%0d", i), 32'(o_ovf[i]), 32'(movf[i]));
            if (o_busy[i] && !prev_busy[i]) rise_cyc[i] = cyc;
            if (!o_busy[i] && prev_busy[i]) last_len[i] = cyc - rise_cyc[i];
            prev_busy[i] = o_busy[i];
        end
    endtask

    task automatic idle_inputs();
        for (int unsigned i = 0; i < NI; i++) begin
            we[i] = 1'b0; wd[i] = '0; clr[i] = 1'b0;
        end
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n;
        logic        done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            step();
            n++;
            done = 1'b1;
            for (int unsigned i = 0; i < NI; i++) if (o_busy[i] || !o_emp[i]) done = 1'b0;
        end
        check_eq("drain_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int unsigned wr_cyc;
        int unsigned thr;
        for (int unsigned i = 0; i < NI; i++) begin
            prev_busy[i] = 1'b0; rise_cyc[i] = 0; last_len[i] = 0; movf[i] = 1'b0;
        end
        idle_inputs();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Single frames: 0xA5 on 8N1, 0x83 on 7E2, 0x00 on 8O1.
        we[0] = 1'b1; wd[0] = 8'hA5;
        we[1] = 1'b1; wd[1] = 8'h83;
        we[2] = 1'b1; wd[2] = 8'h00;
        wr_cyc = cyc;
        step();
        idle_inputs();
        repeat (50) step();
        check_eq("lat_a", rise_cyc[0] - wr_cyc, 2);
        check_eq("lat_b", rise_cyc[1] - wr_cyc, 2);
        check_eq("len_a", last_len[0], 40);
        check_eq("len_b", last_len[1], 44);
        check_eq("len_c", last_len[2], 44);

        we[2] = 1'b1; wd[2] = 8'h01;
        step();
        idle_inputs();
        repeat (50) step();

        // Burst of 20 writes per cycle into idle blocks: three are dropped.
        for (int unsigned k = 0; k < 20; k++) begin
            for (int unsigned i = 0; i < NI; i++) begin
                we[i] = 1'b1; wd[i] = 8'($urandom);
            end
            step();
        end
        idle_inputs();
        for (int unsigned i = 0; i < NI; i++) check_eq($sformatf("burst_ovf%0d", i), 32'(o_ovf[i]), 1);
        drain(17 * 44 + 50);

        // Clear, refill past full, then write+clear while full.
        for (int unsigned i = 0; i < NI; i++) clr[i] = 1'b1;
        step();
        idle_inputs();
        check_eq("clr_a", 32'(o_ovf[0]), 0);
        for (int unsigned k = 0; k < 18; k++) begin
            for (int unsigned i = 0; i < NI; i++) begin
                we[i] = 1'b1; wd[i] = 8'($urandom);
            end
            step();
        end
        for (int unsigned i = 0; i < NI; i++) clr[i] = 1'b1;
        step();
        idle_inputs();
        check_eq("ovf_hold_a", 32'(o_ovf[0]), 1);
        for (int unsigned i = 0; i < NI; i++) clr[i] = 1'b1;
        step();
        idle_inputs();
        check_eq("ovf_clr_a", 32'(o_ovf[0]), 0);
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst_tx_a", 32'(o_tx[0]), 1);
        check_eq("rst_cnt_a", 32'(o_cnt[0]), 0);
        step();

        // Random traffic at varying write densities, with sporadic clears and resets.
        for (int unsigned blk = 0; blk < 8; blk++) begin
            thr = (blk % 4 == 0) ? 2 : (blk % 4 == 1) ? 8 : (blk % 4 == 2) ? 30 : 90;
            for (int unsigned n = 0; n < 500; n++) begin
                for (int unsigned i = 0; i < NI; i++) begin
                    we[i]  = ($urandom_range(0, 99) < thr);
                    wd[i]  = 8'($urandom);
                    clr[i] = ($urandom_range(0, 63) == 0);
                end
                rst = ($urandom_range(0, 1499) == 0);
                step();
            end
        end
        idle_inputs();
        rst = 1'b0;
        drain(17 * 44 + 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter for the core's byte-output path. Memory-mapped stores into the UART window push bytes into an internal FIFO, so the pipeline never stalls on a single in-flight byte. A serialiser drains the FIFO onto `uart_tx` with configurable baud divisor, data width, parity and stop bits. Overflow is reported through a sticky flag and FIFO occupancy through a count.

## Interface
- `CLKS_PER_BIT`, 434 — sysclk cycles per serial bit; ≥2.
- `DATA_BITS`, 8 — data bits per frame, 5..8.
- `PARITY`, 0 — 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1 — 1 or 2.
- `FIFO_DEPTH`, 16 — entries, power of two, ≥2.

Ports:
- `sysclk` in 1 — the single clock; all logic on its rising edge.
- `cpu_reset` in 1 — reset, synchronous and active-high.
- `wr_en` in 1 — push `wr_data` this cycle.
- `wr_data` in 8 — byte; bits ≥ `DATA_BITS` are ignored.
- `ovf_clear` in 1 — clears `overflow`.
- `full` out 1 — FIFO holds `FIFO_DEPTH` entries.
- `empty` out 1 — FIFO holds 0 entries.
- `count` out $clog2(FIFO_DEPTH+1) — current occupancy.
- `busy` out 1 — serialiser not in IDLE.
- `overflow` out 1 — sticky; set when a write is dropped.
- `uart_tx` out 1 — serial line, registered, idles high.

## Operation
- FIFO push: `wr_en && !full` stores `wr_data`. `wr_en && full` drops the byte and sets `overflow`, even if a pop happens in the same cycle.
- Simultaneous push and pop with 0 < count < DEPTH leaves `count` unchanged.
- Pointers wrap modulo `FIFO_DEPTH`.
- `overflow`: set has priority over `ovf_clear` in the same cycle.
- Serialiser FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: if `!empty`, pop the head into the shift register, go to START.
  - START: `uart_tx`=0 for one bit time.
  - DATA: `DATA_BITS` bits, LSB first.
  - PAR: only if `PARITY`≠0. Odd parity makes the count of ones in data+parity odd; even makes it even.
  - STOP: `uart_tx`=1 for `STOP_BITS` bit times.
- End of STOP: if `!empty`, pop and go straight to START with no idle gap; otherwise go to IDLE.
- One bit time is counted by a `CLKS_PER_BIT` down-counter. A bit-index counter tracks position within DATA and STOP.
- Frame length: `CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS)` cycles.
- `busy`=1 in every state except IDLE.

## Timing
- Reset values: `uart_tx`=1, `full`=0, `empty`=1, `count`=0, `busy`=0, `overflow`=0. FSM goes to IDLE; pointers and counters go to 0.
- Reset mid-frame: `uart_tx` is 1 on the next cycle and the FIFO contents are discarded.
- `full`, `empty` and `count` update the cycle after the push or pop.
- Write into an empty, idle block at cycle 0:
  - cycle 1: `empty`=0, pop occurs.
  - cycle 2: `uart_tx` falls, `busy`=1.
  - Write-to-start-edge latency is 2 cycles.
- Each line level holds exactly `CLKS_PER_BIT` cycles per bit. The line never glitches between bits.
- Back-to-back frames: the start bit of frame N+1 begins the cycle after the last stop-bit cycle of frame N.

## Structure
- Package `uart_pkg` holds:
  - `parity_e` (NONE, ODD, EVEN);
  - `tx_state_e` (IDLE, START, DATA, PAR, STOP);
  - a `uart_frame_len` function.
- Sub-module `sync_fifo`, parametrised in width and depth. It exposes push/pop/full/empty/count and supports same-cycle push+pop.
- `uart_tx_fifo` contains the FSM, baud counter, bit counter, shift register and parity generation.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 unless noted.
- Reset: hold `cpu_reset` 3 cycles -> all outputs at reset values; `uart_tx`=1 throughout.
- 8N1, write 0xA5 -> line 0 | 1,0,1,0,0,1,0,1 | 1, each level held 4 cycles; start edge 2 cycles after the write; `busy` falls 40 cycles after it rose.
- `DATA_BITS`=7, `PARITY`=2, `STOP_BITS`=2, write 0x83 -> data 1,1,0,0,0,0,0, parity 0, two stop bits; frame is 44 cycles; bit 7 of 0x83 ignored.
- `PARITY`=1, write 0x00 -> parity bit 1; write 0x01 -> parity bit 0.
- Burst of 20 writes at `FIFO_DEPTH`=16, one per cycle while idle:
  - `full` asserts;
  - exactly 3 writes dropped: one byte is popped before the FIFO fills;
  - `overflow`=1;
  - 17 frames sent back-to-back with no idle gap, in write order;
  - `count` reaches 0, then `busy` falls.
- Simultaneous `wr_en` with `full` and `ovf_clear` -> `overflow` stays 1. Later `ovf_clear` alone -> 0. Mid-frame `cpu_reset` -> `uart_tx`=1 next cycle, `count`=0.
